keypad_cmd_gen: RTL

- Front-end command initiator for the RPN stack calculator.
- Conditions three raw push-button keys (insert, add, mult) and the 16-bit switch bank:
  - synchronises and debounces each key;
  - turns each press into exactly one single-cycle command pulse;
  - paces the pulses against the calculator FSM's busy indication.
- Sits between the board pins and the calculator command inputs (insert/add/mult/sw).

---
 rtl/keypad_cmd_gen.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/keypad_cmd_gen.sv
// Keypad front end: synchronises and debounces three push-buttons, records presses
// as pending commands, and issues them one at a time, paced against the calculator's busy.
module keypad_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int GUARD_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_insert_n,
    input  logic        key_add_n,
    input  logic        key_mult_n,
    input  logic [15:0] sw,
    input  logic        busy,
    output logic        insert,
    output logic        add,
    output logic        mult,
    output logic [15:0] data,
    output logic [2:0]  pending,
    output logic [7:0]  cmd_count
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0]    GUARD_LAST = GW'(GUARD_CYCLES - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [2:0]    keys_n;
    logic [2:0]    press;
    logic [1:0]    fill_reg;
    logic          fill_done;

    state_t        state_reg, state_next;
    logic [GW-1:0] guard_reg, guard_next;
    logic [2:0]    pending_reg, pending_next;
    logic [2:0]    issue;
    logic [15:0]   data_cap_reg;
    logic [15:0]   data_reg;
    logic          insert_reg, add_reg, mult_reg;
    logic [7:0]    cmd_count_reg;

    assign keys_n    = {key_mult_n, key_add_n, key_insert_n};
    assign fill_done = fill_reg[1];

    // Counts the two cycles the synchronisers need to hold real pin levels after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_reg <= 2'd0;
        end else if (!fill_done) begin
            fill_reg <= fill_reg + 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            logic             sync1_reg, sync2_reg, stable_reg, armed_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             k_s, accept;

            assign k_s    = ~sync2_reg;
            assign accept = (k_s != stable_reg) && (cnt_reg == DB_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg  <= 1'b1;
                    sync2_reg  <= 1'b1;
                    stable_reg <= 1'b0;
                    armed_reg  <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= keys_n[gi];
                    sync2_reg <= sync1_reg;
                    if (k_s == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (accept) begin
                        stable_reg <= k_s;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                    // A key held through reset must be seen released before it can press.
                    if (fill_done && !k_s) begin
                        armed_reg <= 1'b1;
                    end
                end
            end

            assign press[gi] = accept & k_s & armed_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        guard_next = guard_reg;
        issue      = 3'b000;
        case (state_reg)
            IDLE: begin
                if (!busy && (pending_reg != 3'b000)) begin
                    if (pending_reg[0])      issue = 3'b001;
                    else if (pending_reg[1]) issue = 3'b010;
                    else                     issue = 3'b100;
                    state_next = WAIT;
                    guard_next = '0;
                end
            end
            WAIT: begin
                if (guard_reg >= GUARD_LAST) begin
                    if (!busy) state_next = IDLE;
                end else begin
                    guard_next = guard_reg + GW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // A fresh press on the bit being issued keeps it set.
        pending_next = (pending_reg & ~issue) | press;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            guard_reg     <= '0;
            pending_reg   <= 3'b000;
            data_cap_reg  <= 16'd0;
            data_reg      <= 16'd0;
            insert_reg    <= 1'b0;
            add_reg       <= 1'b0;
            mult_reg      <= 1'b0;
            cmd_count_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            guard_reg   <= guard_next;
            pending_reg <= pending_next;
            insert_reg  <= issue[0];
            add_reg     <= issue[1];
            mult_reg    <= issue[2];
            if (press[0]) begin
                data_cap_reg <= sw;
            end
            if (issue[0]) begin
                data_reg <= data_cap_reg;
            end
            if (issue != 3'b000) begin
                cmd_count_reg <= cmd_count_reg + 8'd1;
            end
        end
    end

    assign insert    = insert_reg;
    assign add       = add_reg;
    assign mult      = mult_reg;
    assign data      = data_reg;
    assign pending   = pending_reg;
    assign cmd_count = cmd_count_reg;

endmodule
